bw_mul_wb_ctrl: RTL
===================

Name: bw_mul_wb_ctrl

Overview:
- Wishbone slave controller that sequences the Baugh-Wooley signed multiplier datapath.
- Latches operands from bus writes and drives them onto the multiplier inputs.
- Waits a programmable settle time, captures the product into a result register and reports completion through status and an optional IRQ.
- Sits inside user_project_wrapper, between the Wishbone port and the combinational multiplier.

Parameters:
- DATA_W, 8: operand width (signed two's complement).
- PROD_W, 16: captured product width; must equal 2*DATA_W.
- BASE_ADDR, 32'h3000_0000: register window base. Decode is wbs_adr_i[31:4]==BASE_ADDR[31:4].
- SETTLE_RST, 4'd2: reset value of CFG.settle.

Ports:
- wb_clk_i  in  1  system clock, rising edge.
- wb_rst_ni  in  1  asynchronous active-low reset.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte selects.
- wbs_adr_i  in  32  address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- mul_a  out  DATA_W  multiplier operand A.
- mul_b  out  DATA_W  multiplier operand B.
- mul_p  in  PROD_W  multiplier product (combinational from mul_a/mul_b).
- busy_o  out  1  job in flight.
- irq_o  out  1  completion interrupt (see Optional Feature).

Behaviour:
- Reset (async assert, sync deassert external): all outputs and registers are 0, except CFG.settle=SETTLE_RST. FSM enters IDLE.
- Register map (offset = adr[3:2]):
  - 0 OPND (RW): [7:0]=A, [15:8]=B.
  - 1 RES (RO): [15:0]=product, [31:16]=sign-extension of product.
  - 2 STAT: bit0 busy (RO), bit1 done (RO), bit2 err (W1C).
  - 3 CFG (RW): [3:0] settle.
- Bus handshake:
  - A request is cyc&stb&decode-hit&!ack.
  - ack is asserted exactly one cycle after the request and deasserts the next cycle, so back-to-back accesses take 2 cycles each.
  - Misses never ack.
  - wbs_dat_o is valid while ack=1 and 0 otherwise.
  - Writes honour wbs_sel_i per byte.
- Job start: a write to OPND with sel[0] or sel[1] set, while IDLE, updates A/B, clears done and moves the FSM to DRIVE.
- OPND write while busy: data is dropped, err is set, ack is still given.
- FSM:
  - IDLE: mul_a/mul_b hold the last operands.
  - DRIVE: 1 cycle; loads the counter with settle.
  - SETTLE: decrement each cycle; leave when the counter is 0. settle=0 skips straight to CAPTURE next cycle.
  - CAPTURE: RES<=mul_p; done<=1; return to IDLE.
  - Latency from the OPND ack edge to done=1 is settle+3 cycles.
  - busy_o=1 in DRIVE/SETTLE/CAPTURE.
- Reading RES clears done in the ack cycle. If CAPTURE occurs in the same cycle, the set wins.
- Writing CFG mid-job affects only the next job.
- Reset asserted mid-job aborts immediately; RES is cleared.
- Product is the signed full 2*DATA_W result. No truncation or overflow is possible.

Optional Feature:
- Macro: BW_MUL_CTRL_IRQ_EN.
- Defined:
  - Adds CFG bit4 ie (reset 0).
  - irq_o = done & ie, a level output cleared by a RES read.
- Undefined:
  - irq_o is tied to 0.
  - CFG bit4 reads 0 and writes to it are ignored.

Test Plan:
- Reset, then read STAT and CFG -> STAT=0x0, CFG=0x2, irq_o=0, mul_a=mul_b=0.
- Write OPND=0x0005_FD (A=-3, B=5), poll STAT -> done after 5 cycles (settle=2); RES=0xFFFF_FFF1; the RES read clears done.
- Write CFG=0, then OPND A=0x80 B=0x80 -> done 3 cycles after ack; RES=0x0000_4000. Then A=0x7F B=0x7F -> RES=0x0000_3F01.
- Write OPND twice back-to-back with settle=4 -> second write acked, STAT.err=1, RES from the first operands. Write STAT bit2=1 -> err=0.
- Bus negative checks:
  - Access at BASE_ADDR+0x10 -> no ack.
  - Write OPND with sel=0b0010 -> only B updates and a job starts.
- With BW_MUL_CTRL_IRQ_EN defined and CFG=0x12:
  - Job completes -> irq_o rises with done; the RES read drops it.
  - Assert reset mid-SETTLE -> busy_o=0, RES=0, irq_o=0.

Source files
------------

// File: rtl/bw_mul_wb_ctrl.sv
// Wishbone slave sequencing the combinational Baugh-Wooley multiplier: latches operands,
// waits CFG.settle cycles, captures the product. Optional IRQ enabled by BW_MUL_CTRL_IRQ_EN.
module bw_mul_wb_ctrl #(
  parameter int          DATA_W     = 8,
  parameter int          PROD_W     = 16,
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter logic [3:0]  SETTLE_RST = 4'd2
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic [DATA_W-1:0] mul_a,
  output logic [DATA_W-1:0] mul_b,
  input  logic [PROD_W-1:0] mul_p,
  output logic              busy_o,
  output logic              irq_o
);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_SETTLE, S_CAPTURE} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [3:0]          settle_q, settle_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic [PROD_W-1:0]   res_q, res_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                ack_q, ack_d;
  logic [31:0]         dat_q, dat_d;
  logic                ie_q, ie_d;

  logic                hit, req, wr, rd;
  logic [1:0]          off;
  logic [31:0]         rdata;
  logic                unused_bits;

  assign unused_bits = ^{wbs_dat_i[31:2*DATA_W], wbs_sel_i[3:2], wbs_adr_i[1:0]};

  assign hit = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign req = wbs_cyc_i & wbs_stb_i & hit & ~ack_q;
  assign wr  = req & wbs_we_i;
  assign rd  = req & ~wbs_we_i;
  assign off = wbs_adr_i[3:2];

  always_comb begin
    rdata = '0;
    unique case (off)
      2'd0: begin
        rdata[DATA_W-1:0]        = a_q;
        rdata[2*DATA_W-1:DATA_W] = b_q;
      end
      2'd1: rdata = {{(32-PROD_W){res_q[PROD_W-1]}}, res_q};
      2'd2: rdata[2:0] = {err_q, done_q, state_q != S_IDLE};
      default: begin
        rdata[3:0] = settle_q;
        rdata[4]   = ie_q;
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    settle_d = settle_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    done_d   = done_q;
    err_d    = err_q;
    ie_d     = ie_q;
    ack_d    = req;
    dat_d    = rd ? rdata : '0;

    // RES read clear is applied first so a same-cycle CAPTURE set overrides it
    if (rd && off == 2'd1) done_d = 1'b0;
    if (wr && off == 2'd0 && state_q != S_IDLE) err_d = 1'b1;
    if (wr && off == 2'd2 && wbs_sel_i[0] && wbs_dat_i[2]) err_d = 1'b0;
    if (wr && off == 2'd3 && wbs_sel_i[0]) begin
      settle_d = wbs_dat_i[3:0];
`ifdef BW_MUL_CTRL_IRQ_EN
      ie_d     = wbs_dat_i[4];
`endif
    end

    unique case (state_q)
      S_IDLE: begin
        if (wr && off == 2'd0 && (wbs_sel_i[0] || wbs_sel_i[1])) begin
          if (wbs_sel_i[0]) a_d = wbs_dat_i[DATA_W-1:0];
          if (wbs_sel_i[1]) b_d = wbs_dat_i[2*DATA_W-1:DATA_W];
          done_d  = 1'b0;
          state_d = S_DRIVE;
        end
      end
      S_DRIVE: begin
        cnt_d   = settle_q;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == '0) state_d = S_CAPTURE;
        else             cnt_d   = cnt_q - 4'd1;
      end
      default: begin
        res_d   = mul_p;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      settle_q <= SETTLE_RST;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      ie_q     <= 1'b0;
      ack_q    <= 1'b0;
      dat_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      settle_q <= settle_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      done_q   <= done_d;
      err_q    <= err_d;
      ie_q     <= ie_d;
      ack_q    <= ack_d;
      dat_q    <= dat_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign mul_a     = a_q;
  assign mul_b     = b_q;
  assign busy_o    = (state_q != S_IDLE);
`ifdef BW_MUL_CTRL_IRQ_EN
  assign irq_o     = done_q & ie_q;
`else
  assign irq_o     = 1'b0;
`endif

endmodule
